// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller.
// The select encodings are also used by the datapath operand mux wiring.
package forward_ctrl_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_SEL_RF  = 2'd0;
    localparam fwd_sel_t FWD_SEL_WB  = 2'd1;
    localparam fwd_sel_t FWD_SEL_MEM = 2'd2;

endpackage

// File: rtl/forward_ctrl_match.sv
// Picks the forwarding source for one EX operand from the MEM and WB destination tuples.
// The youngest producer (MEM) wins when both stages write the same register.
module fwd_match
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
        wb_hit  = wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == src);
        sel     = FWD_SEL_RF;
        if (mem_hit) begin
            sel = FWD_SEL_MEM;
        end else if (wb_hit) begin
            sel = FWD_SEL_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding selects and load-use stall for the 5-stage pipeline, using a shadow copy
// of the EX/MEM/WB destination info that advances in lock-step with the datapath.
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  pipe_hold,
    input  logic                  flush_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  load_use_stall
);

    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_mem_read_q, ex_mem_read_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_reg_write_q, mem_reg_write_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_reg_write_q, wb_reg_write_d;

    logic [REG_ADDR_W-1:0] src [2];
    logic [1:0]            sel_raw [2];

    // A load in EX whose result is needed by ID cannot be forwarded in time.
    always_comb begin
        load_use_stall = id_valid && ex_valid_q && ex_mem_read_q && ex_reg_write_q &&
                         (ex_rd_q != '0) && ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    end

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        mem_valid_d     = mem_valid_q;
        mem_rd_d        = mem_rd_q;
        mem_reg_write_d = mem_reg_write_q;
        wb_valid_d      = wb_valid_q;
        wb_rd_d         = wb_rd_q;
        wb_reg_write_d  = wb_reg_write_q;
        if (!pipe_hold) begin
            wb_valid_d      = mem_valid_q;
            wb_rd_d         = mem_rd_q;
            wb_reg_write_d  = mem_reg_write_q;
            mem_valid_d     = ex_valid_q;
            mem_rd_d        = ex_rd_q;
            mem_reg_write_d = ex_reg_write_q;
            // A bubble only clears valid; its stale fields are never looked at.
            ex_valid_d      = id_valid && !flush_ex && !load_use_stall;
            ex_rs1_d        = id_rs1;
            ex_rs2_d        = id_rs2;
            ex_rd_d         = id_rd;
            ex_reg_write_d  = id_reg_write;
            ex_mem_read_d   = id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= mem_valid_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
        end
    end

    assign src[0] = ex_rs1_q;
    assign src[1] = ex_rs2_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_match
            fwd_match #(
                .REG_ADDR_W (REG_ADDR_W)
            ) u_match (
                .src           (src[gi]),
                .mem_valid     (mem_valid_q),
                .mem_reg_write (mem_reg_write_q),
                .mem_rd        (mem_rd_q),
                .wb_valid      (wb_valid_q),
                .wb_reg_write  (wb_reg_write_q),
                .wb_rd         (wb_rd_q),
                .sel           (sel_raw[gi])
            );
        end
    endgenerate

    assign fwd_a_sel = ex_valid_q ? sel_raw[0] : FWD_SEL_RF;
    assign fwd_b_sel = ex_valid_q ? sel_raw[1] : FWD_SEL_RF;

endmodule
